// File: rtl/ahb_lite_arbiter_2m.sv
// Two-master AHB-Lite arbiter sharing a single slave port.
// Round-robin grant on transfer/burst boundaries; locked sequences are never split.
module ahb_lite_arbiter_2m #(
    parameter int   ADDRESSWIDTH   = 28,
    parameter int   DATAWIDTH      = 32,
    parameter logic DEFAULT_MASTER = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic [ADDRESSWIDTH-1:0] m0_haddr,
    input  logic [1:0]              m0_htrans,
    input  logic                    m0_hwrite,
    input  logic [2:0]              m0_hsize,
    input  logic [2:0]              m0_hburst,
    input  logic                    m0_hmastlock,
    input  logic [DATAWIDTH-1:0]    m0_hwdata,
    output logic                    m0_hready,
    output logic                    m0_hresp,
    output logic [DATAWIDTH-1:0]    m0_hrdata,

    input  logic [ADDRESSWIDTH-1:0] m1_haddr,
    input  logic [1:0]              m1_htrans,
    input  logic                    m1_hwrite,
    input  logic [2:0]              m1_hsize,
    input  logic [2:0]              m1_hburst,
    input  logic                    m1_hmastlock,
    input  logic [DATAWIDTH-1:0]    m1_hwdata,
    output logic                    m1_hready,
    output logic                    m1_hresp,
    output logic [DATAWIDTH-1:0]    m1_hrdata,

    output logic [ADDRESSWIDTH-1:0] s_haddr,
    output logic [1:0]              s_htrans,
    output logic                    s_hwrite,
    output logic [2:0]              s_hsize,
    output logic [2:0]              s_hburst,
    output logic                    s_hmastlock,
    output logic [DATAWIDTH-1:0]    s_hwdata,
    output logic                    s_hsel,
    output logic                    s_hready,
    input  logic                    s_hreadyout,
    input  logic                    s_hresp,
    input  logic [DATAWIDTH-1:0]    s_hrdata,
    output logic                    s_hmaster
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    logic       addr_owner;
    logic       data_valid;
    logic       data_owner;
    logic       last_winner;
    logic [1:0] other_htrans;
    logic       boundary;

    // Address phase follows addr_owner purely combinationally, so s_hreadyout
    // never reaches the address outputs.
    always_comb begin
        if (addr_owner) begin
            s_haddr     = m1_haddr;
            s_htrans    = m1_htrans;
            s_hwrite    = m1_hwrite;
            s_hsize     = m1_hsize;
            s_hburst    = m1_hburst;
            s_hmastlock = m1_hmastlock;
            other_htrans = m0_htrans;
        end else begin
            s_haddr     = m0_haddr;
            s_htrans    = m0_htrans;
            s_hwrite    = m0_hwrite;
            s_hsize     = m0_hsize;
            s_hburst    = m0_hburst;
            s_hmastlock = m0_hmastlock;
            other_htrans = m1_htrans;
        end
        s_hwdata = data_owner ? m1_hwdata : m0_hwdata;
    end

    assign boundary = ((s_htrans == HTRANS_IDLE) ||
                       ((s_htrans == HTRANS_NONSEQ) && (s_hburst == HBURST_SINGLE))) &&
                      !s_hmastlock;

    // A master sees ready while it owns the address phase or its data phase is in flight.
    assign m0_hready = s_hreadyout && (!addr_owner || (data_valid && !data_owner));
    assign m1_hready = s_hreadyout && ( addr_owner || (data_valid &&  data_owner));
    assign m0_hresp  = s_hresp && data_valid && !data_owner;
    assign m1_hresp  = s_hresp && data_valid &&  data_owner;
    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;

    assign s_hsel    = 1'b1;
    assign s_hready  = s_hreadyout;
    assign s_hmaster = addr_owner;

    // Wait states freeze everything; otherwise the presented transfer moves into
    // its data phase and the grant may rotate if this cycle is a boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_owner  <= DEFAULT_MASTER;
            data_valid  <= 1'b0;
            data_owner  <= DEFAULT_MASTER;
            last_winner <= DEFAULT_MASTER;
        end else if (s_hreadyout) begin
            data_valid <= s_htrans[1];
            data_owner <= addr_owner;
            if (s_htrans == HTRANS_NONSEQ) begin
                last_winner <= addr_owner;
            end
            if (boundary && (other_htrans == HTRANS_NONSEQ)) begin
                if (s_htrans == HTRANS_IDLE) begin
                    addr_owner <= ~addr_owner;
                end else if ((s_htrans == HTRANS_NONSEQ) && (last_winner == addr_owner)) begin
                    addr_owner <= ~addr_owner;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_arbiter_2m.sv
// Directed self-checking bench for ahb_lite_arbiter_2m: reset, handoff,
// round-robin, bursts, locked sequences with ERROR, and mid-transfer reset.
module tb_ahb_lite_arbiter_2m;

    localparam int AW = 28;
    localparam int DW = 32;

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] m0_haddr, m1_haddr, s_haddr;
    logic [1:0]    m0_htrans, m1_htrans, s_htrans;
    logic          m0_hwrite, m1_hwrite, s_hwrite;
    logic [2:0]    m0_hsize, m1_hsize, s_hsize;
    logic [2:0]    m0_hburst, m1_hburst, s_hburst;
    logic          m0_hmastlock, m1_hmastlock, s_hmastlock;
    logic [DW-1:0] m0_hwdata, m1_hwdata, s_hwdata;
    logic          m0_hready, m1_hready, m0_hresp, m1_hresp;
    logic [DW-1:0] m0_hrdata, m1_hrdata, s_hrdata;
    logic          s_hsel, s_hready, s_hreadyout, s_hresp, s_hmaster;

    int vectors;
    int miscompares;

    ahb_lite_arbiter_2m #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .DEFAULT_MASTER(1'b0)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
        .m0_hburst(m0_hburst), .m0_hmastlock(m0_hmastlock), .m0_hwdata(m0_hwdata),
        .m0_hready(m0_hready), .m0_hresp(m0_hresp), .m0_hrdata(m0_hrdata),
        .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
        .m1_hburst(m1_hburst), .m1_hmastlock(m1_hmastlock), .m1_hwdata(m1_hwdata),
        .m1_hready(m1_hready), .m1_hresp(m1_hresp), .m1_hrdata(m1_hrdata),
        .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
        .s_hburst(s_hburst), .s_hmastlock(s_hmastlock), .s_hwdata(s_hwdata),
        .s_hsel(s_hsel), .s_hready(s_hready), .s_hreadyout(s_hreadyout),
        .s_hresp(s_hresp), .s_hrdata(s_hrdata), .s_hmaster(s_hmaster)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_all();
        m0_haddr = '0; m0_htrans = 2'b00; m0_hwrite = 1'b0; m0_hsize = 3'b010;
        m0_hburst = 3'b000; m0_hmastlock = 1'b0; m0_hwdata = '0;
        m1_haddr = '0; m1_htrans = 2'b00; m1_hwrite = 1'b0; m1_hsize = 3'b010;
        m1_hburst = 3'b000; m1_hmastlock = 1'b0; m1_hwdata = '0;
        s_hreadyout = 1'b1; s_hresp = 1'b0; s_hrdata = '0;
    endtask

    // Leaves time at posedge+1 with reset released, ready to drive a cycle.
    task automatic do_reset();
        idle_all();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        vectors++; if (s_hmaster !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_hmaster: got %0h want 0", s_hmaster); end
        vectors++; if (m0_hready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_m0_hready: got %0h want 1", m0_hready); end
        vectors++; if (m1_hready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_m1_hready: got %0h want 0", m1_hready); end
        vectors++; if (s_hsel !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_hsel: got %0h want 1", s_hsel); end
        s_hresp = 1'b1;
        #1;
        vectors++; if ({m0_hresp, m1_hresp} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_hresp: got %b want 00", {m0_hresp, m1_hresp}); end
        s_hresp = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_write();
        do_reset();
        m0_haddr = 28'h000_0010; m0_htrans = 2'b10; m0_hwrite = 1'b1;
        @(negedge clk);
        vectors++; if (s_haddr !== 28'h10) begin miscompares++; $display("[TB] FAIL wr_haddr: got %0h want 10", s_haddr); end
        vectors++; if (s_hwrite !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_hwrite: got %0h want 1", s_hwrite); end
        vectors++; if (m0_hready !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_m0_hready_a: got %0h want 1", m0_hready); end
        vectors++; if (m1_hready !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_m1_hready_a: got %0h want 0", m1_hready); end
        next_cycle();
        m0_htrans = 2'b00; m0_hwrite = 1'b0; m0_hwdata = 32'hDEADBEEF; m1_hwdata = 32'h1111_2222;
        @(negedge clk);
        vectors++; if (s_hwdata !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL wr_hwdata: got %0h want deadbeef", s_hwdata); end
        vectors++; if (s_hmaster !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_hmaster: got %0h want 0", s_hmaster); end
        vectors++; if (m0_hready !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_m0_hready_d: got %0h want 1", m0_hready); end
        vectors++; if (m1_hready !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_m1_hready_d: got %0h want 0", m1_hready); end
        next_cycle();
    endtask

    task automatic test_handoff_read();
        do_reset();
        m1_haddr = 28'h100; m1_htrans = 2'b10; m1_hwrite = 1'b0;
        @(negedge clk);
        vectors++; if (m1_hready !== 1'b0) begin miscompares++; $display("[TB] FAIL ho_m1_stall: got %0h want 0", m1_hready); end
        vectors++; if (s_hmaster !== 1'b0) begin miscompares++; $display("[TB] FAIL ho_hmaster_a: got %0h want 0", s_hmaster); end
        next_cycle();
        @(negedge clk);
        vectors++; if (s_hmaster !== 1'b1) begin miscompares++; $display("[TB] FAIL ho_hmaster_b: got %0h want 1", s_hmaster); end
        vectors++; if (s_haddr !== 28'h100) begin miscompares++; $display("[TB] FAIL ho_haddr: got %0h want 100", s_haddr); end
        vectors++; if (s_htrans !== 2'b10) begin miscompares++; $display("[TB] FAIL ho_htrans: got %0h want 2", s_htrans); end
        vectors++; if (m1_hready !== 1'b1) begin miscompares++; $display("[TB] FAIL ho_m1_ready_a: got %0h want 1", m1_hready); end
        next_cycle();
        m1_htrans = 2'b00; s_hrdata = 32'hCAFE_0123;
        @(negedge clk);
        vectors++; if (m1_hrdata !== 32'hCAFE_0123) begin miscompares++; $display("[TB] FAIL ho_hrdata: got %0h want cafe0123", m1_hrdata); end
        vectors++; if (m1_hready !== 1'b1) begin miscompares++; $display("[TB] FAIL ho_m1_ready_d: got %0h want 1", m1_hready); end
        vectors++; if (m0_hready !== 1'b0) begin miscompares++; $display("[TB] FAIL ho_m0_ready_d: got %0h want 0", m0_hready); end
        next_cycle();
    endtask

    // last_winner lags one accepted transfer, so each master holds two slots in turn.
    task automatic test_back_to_back();
        logic exp_master [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [AW-1:0] exp_addr;
        do_reset();
        m0_haddr = 28'h200; m0_htrans = 2'b10;
        m1_haddr = 28'h300; m1_htrans = 2'b10;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_addr = exp_master[i] ? 28'h300 : 28'h200;
            vectors++; if (s_hmaster !== exp_master[i]) begin miscompares++; $display("[TB] FAIL rr_hmaster c%0d: got %0h want %0h", i, s_hmaster, exp_master[i]); end
            vectors++; if (s_haddr !== exp_addr) begin miscompares++; $display("[TB] FAIL rr_haddr c%0d: got %0h want %0h", i, s_haddr, exp_addr); end
            next_cycle();
        end
    endtask

    task automatic test_burst();
        logic [1:0] m0_trans_tab [8] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
        logic       rdy_tab      [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       exp_master   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       exp_m0_rdy   [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       exp_m1_rdy   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int beat;
        do_reset();
        m0_hburst = 3'b011;
        m1_haddr = 28'h400; m1_htrans = 2'b10;
        beat = 0;
        for (int i = 0; i < 8; i++) begin
            m0_htrans = m0_trans_tab[i];
            m0_haddr = 28'h1000 + AW'(beat * 4);
            s_hreadyout = rdy_tab[i];
            @(negedge clk);
            vectors++; if (s_hmaster !== exp_master[i]) begin miscompares++; $display("[TB] FAIL burst_hmaster c%0d: got %0h want %0h", i, s_hmaster, exp_master[i]); end
            vectors++; if (m0_hready !== exp_m0_rdy[i]) begin miscompares++; $display("[TB] FAIL burst_m0_hready c%0d: got %0h want %0h", i, m0_hready, exp_m0_rdy[i]); end
            vectors++; if (m1_hready !== exp_m1_rdy[i]) begin miscompares++; $display("[TB] FAIL burst_m1_hready c%0d: got %0h want %0h", i, m1_hready, exp_m1_rdy[i]); end
            if (i == 7) begin
                vectors++; if (s_haddr !== 28'h400) begin miscompares++; $display("[TB] FAIL burst_handoff_haddr: got %0h want 400", s_haddr); end
            end
            if (rdy_tab[i]) beat++;
            next_cycle();
        end
    endtask

    task automatic test_locked_error();
        logic [1:0] m0_trans_tab [7] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        logic [1:0] m1_trans_tab [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        logic       m1_lock_tab  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       rdy_tab      [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       resp_tab     [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       exp_master   [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       exp_m0_rdy   [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       exp_m1_resp  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        m0_haddr = 28'h500; m1_haddr = 28'h600;
        for (int i = 0; i < 7; i++) begin
            m0_htrans = m0_trans_tab[i];
            m1_htrans = m1_trans_tab[i];
            m1_hmastlock = m1_lock_tab[i];
            s_hreadyout = rdy_tab[i];
            s_hresp = resp_tab[i];
            @(negedge clk);
            vectors++; if (s_hmaster !== exp_master[i]) begin miscompares++; $display("[TB] FAIL lock_hmaster c%0d: got %0h want %0h", i, s_hmaster, exp_master[i]); end
            vectors++; if (m0_hready !== exp_m0_rdy[i]) begin miscompares++; $display("[TB] FAIL lock_m0_hready c%0d: got %0h want %0h", i, m0_hready, exp_m0_rdy[i]); end
            vectors++; if (m1_hresp !== exp_m1_resp[i]) begin miscompares++; $display("[TB] FAIL lock_m1_hresp c%0d: got %0h want %0h", i, m1_hresp, exp_m1_resp[i]); end
            vectors++; if (m0_hresp !== 1'b0) begin miscompares++; $display("[TB] FAIL lock_m0_hresp c%0d: got %0h want 0", i, m0_hresp); end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_transfer();
        do_reset();
        m1_haddr = 28'h700; m1_htrans = 2'b10;
        next_cycle();
        next_cycle();
        m1_htrans = 2'b00; s_hreadyout = 1'b0;
        @(negedge clk);
        vectors++; if (s_hmaster !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_pre_hmaster: got %0h want 1", s_hmaster); end
        vectors++; if (m1_hready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_pre_wait: got %0h want 0", m1_hready); end
        #1 s_hreadyout = 1'b1; s_hresp = 1'b1;
        #1;
        vectors++; if (m1_hresp !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_pre_m1_hresp: got %0h want 1", m1_hresp); end
        #1 reset_n = 1'b0;
        #1;
        vectors++; if (s_hmaster !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_hmaster: got %0h want 0", s_hmaster); end
        vectors++; if (m0_hready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_m0_hready: got %0h want 1", m0_hready); end
        vectors++; if (m1_hready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_m1_hready: got %0h want 0", m1_hready); end
        vectors++; if ({m0_hresp, m1_hresp} !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_data_valid: got %b want 00", {m0_hresp, m1_hresp}); end
        vectors++; if (s_haddr !== 28'h0) begin miscompares++; $display("[TB] FAIL rst_haddr: got %0h want 0", s_haddr); end
        next_cycle();
        reset_n = 1'b1;
        s_hresp = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        idle_all();
        reset_n = 1'b0;
        test_reset();
        test_single_write();
        test_handoff_read();
        test_back_to_back();
        test_burst();
        test_locked_error();
        test_reset_mid_transfer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
